// File: rtl/fetch_ctrl_if.sv
// Control-flow bus between the fetch sequencer and the PC / decode side.
// The master drives the fetched op and flags; the slave (fetch_ctrl) returns PC control.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_addr;
    logic              instr_valid;
    logic              br_en;
    logic [2:0]        br_op;
    logic [ADDR_W-1:0] br_target;
    logic              flag_z;
    logic              flag_c;
    logic              resume;
    logic              is_jmp;
    logic [ADDR_W-1:0] jmp_target;
    logic              stall;
    logic              halted;
    logic [SP_W-1:0]   sp;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output pc_addr, instr_valid, br_en, br_op, br_target, flag_z, flag_c, resume,
        input  is_jmp, jmp_target, stall, halted, sp, err_ovf, err_unf
    );

    modport slave (
        input  pc_addr, instr_valid, br_en, br_op, br_target, flag_z, flag_c, resume,
        output is_jmp, jmp_target, stall, halted, sp, err_ovf, err_unf
    );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer: resolves JMP/Jcc/CALL/RET/HALT each cycle and steers the PC load.
// PC control is combinational from state and inputs; state, stack and errors are registered.
module fetch_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.slave bus
);
    localparam int unsigned     SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned     IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;
    typedef enum logic [2:0] {
        OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_CALL, OP_RET, OP_HALT
    } op_e;

    state_e            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              taken;
    logic              is_jmp;
    logic              stall;
    logic [ADDR_W-1:0] jmp_target;
    op_e               op;

    assign op       = op_e'(bus.br_op);
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = bus.flag_z;
            OP_JNZ:  taken = !bus.flag_z;
            OP_JC:   taken = bus.flag_c;
            OP_JNC:  taken = !bus.flag_c;
            default: taken = 1'b0;
        endcase
    end

    // Default is "hold": jump to the current PC, since the PC otherwise increments.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        is_jmp     = 1'b1;
        jmp_target = bus.pc_addr;
        stall      = 1'b0;
        case (state_q)
            S_BOOT: begin
                jmp_target = '0;
                stall      = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (!bus.instr_valid) begin
                    stall = 1'b1;
                end else if (!bus.br_en) begin
                    is_jmp = 1'b0;
                end else begin
                    case (op)
                        OP_CALL: begin
                            if (sp_q < SP_FULL) begin
                                stack_d[push_idx] = bus.pc_addr + ADDR_W'(1);
                                sp_d              = sp_q + SP_W'(1);
                                jmp_target        = bus.br_target;
                            end else begin
                                ovf_d   = 1'b1;
                                state_d = S_HALT;
                            end
                        end
                        OP_RET: begin
                            if (sp_q != '0) begin
                                jmp_target = stack_q[pop_idx];
                                sp_d       = sp_q - SP_W'(1);
                            end else begin
                                unf_d   = 1'b1;
                                state_d = S_HALT;
                            end
                        end
                        OP_HALT: state_d = S_HALT;
                        default: begin
                            if (taken) begin
                                jmp_target = bus.br_target;
                            end else begin
                                is_jmp = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                stall = 1'b1;
                if (bus.resume && !ovf_q && !unf_q) begin
                    is_jmp  = 1'b0;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are meaningless while sp=0, so the storage needs no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.is_jmp     = is_jmp;
    assign bus.jmp_target = jmp_target;
    assign bus.stall      = stall;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.sp         = sp_q;
    assign bus.err_ovf    = ovf_q;
    assign bus.err_unf    = unf_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl driving a simple PC register.
// Expected outputs come from a queue-based program-flow model; a negedge monitor compares them.
module tb_fetch_ctrl;
    logic clk;
    logic rst;

    fetch_ctrl_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus();

    fetch_ctrl #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The program counter this block steers.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.pc_addr <= 8'd0;
        else     bus.pc_addr <= bus.is_jmp ? bus.jmp_target : bus.pc_addr + 8'd1;
    end

    typedef struct {
        logic       is_jmp;
        logic [7:0] tgt;
        logic       stall;
        logic       halted;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        logic [7:0] pc;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference model: program flow as a PC value, a return-address queue and a few flags.
    logic [7:0] m_pc;
    logic [7:0] stk[$];
    logic       m_boot, m_halt, m_ovf, m_unf;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("pc", bus.pc_addr, e.pc);
                chk("is_jmp", 8'(bus.is_jmp), 8'(e.is_jmp));
                if (e.is_jmp) chk("jmp_target", bus.jmp_target, e.tgt);
                chk("stall", 8'(bus.stall), 8'(e.stall));
                chk("halted", 8'(bus.halted), 8'(e.halted));
                chk("sp", 8'(bus.sp), 8'(e.sp));
                chk("err_ovf", 8'(bus.err_ovf), 8'(e.ovf));
                chk("err_unf", 8'(bus.err_unf), 8'(e.unf));
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic be, input logic [2:0] op,
                        input logic [7:0] t, input logic z, input logic c, input logic res);
        exp_t e;
        logic taken;
        rst             = r;
        bus.instr_valid = v;
        bus.br_en       = be;
        bus.br_op       = op;
        bus.br_target   = t;
        bus.flag_z      = z;
        bus.flag_c      = c;
        bus.resume      = res;
        if (r) begin
            m_boot = 1'b1; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_pc = 8'd0;
            stk.delete();
            e = '{is_jmp: 1'b1, tgt: 8'd0, stall: 1'b1, halted: 1'b0,
                  sp: 3'd0, ovf: 1'b0, unf: 1'b0, pc: 8'd0};
        end else begin
            e = '{is_jmp: 1'b1, tgt: m_pc, stall: 1'b0, halted: m_halt,
                  sp: 3'(stk.size()), ovf: m_ovf, unf: m_unf, pc: m_pc};
            if (m_boot) begin
                e.tgt = 8'd0; e.stall = 1'b1; m_boot = 1'b0;
            end else if (m_halt) begin
                e.stall = 1'b1;
                if (res && !m_ovf && !m_unf) begin e.is_jmp = 1'b0; m_halt = 1'b0; end
            end else if (!v) begin
                e.stall = 1'b1;
            end else if (!be) begin
                e.is_jmp = 1'b0;
            end else if (op == 3'd5) begin
                if (stk.size() < 4) begin stk.push_back(m_pc + 8'd1); e.tgt = t; end
                else begin m_ovf = 1'b1; m_halt = 1'b1; end
            end else if (op == 3'd6) begin
                if (stk.size() > 0) e.tgt = stk.pop_back();
                else begin m_unf = 1'b1; m_halt = 1'b1; end
            end else if (op == 3'd7) begin
                m_halt = 1'b1;
            end else begin
                taken = (op == 3'd0) || (op == 3'd1 && z) || (op == 3'd2 && !z) ||
                        (op == 3'd3 && c) || (op == 3'd4 && !c);
                if (taken) e.tgt = t;
                else       e.is_jmp = 1'b0;
            end
            m_pc = e.is_jmp ? e.tgt : m_pc + 8'd1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(1'b0, 1'b1, 1'b0, 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic br(input logic [2:0] op, input logic [7:0] t, input logic z, input logic c);
        step(1'b0, 1'b1, 1'b1, op, t, z, c, 1'b0);
    endtask

    task automatic idle(input logic res);
        step(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), res);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0; bus.br_en = 1'b0; bus.br_op = 3'd0; bus.br_target = 8'd0;
        bus.flag_z = 1'b0; bus.flag_c = 1'b0; bus.resume = 1'b0;
        @(posedge clk);
        #1;
        // reset, boot, then sequential fetch
        do_rst(); do_rst();
        repeat (5) nop();
        // conditional branches
        br(3'd0, 8'd5, 1'b0, 1'b0);
        br(3'd1, 8'h40, 1'b1, 1'b0);
        br(3'd0, 8'd5, 1'b0, 1'b0);
        br(3'd1, 8'h40, 1'b0, 1'b1);
        br(3'd4, 8'h30, 1'b1, 1'b0);
        br(3'd4, 8'h50, 1'b0, 1'b1);
        br(3'd2, 8'h60, 1'b0, 1'b0);
        br(3'd2, 8'h70, 1'b1, 1'b1);
        br(3'd3, 8'h80, 1'b0, 1'b1);
        br(3'd3, 8'h90, 1'b1, 1'b0);
        // fetch stall
        br(3'd0, 8'd9, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b1, 1'b1, 1'b1);
        nop();
        // call / return, including wrap of the return address
        br(3'd0, 8'h10, 1'b0, 1'b0);
        br(3'd5, 8'h20, 1'b0, 1'b0);
        br(3'd6, 8'h00, 1'b0, 1'b0);
        nop();
        br(3'd0, 8'hFF, 1'b0, 1'b0);
        br(3'd5, 8'h44, 1'b0, 1'b0);
        nop();
        br(3'd6, 8'h00, 1'b0, 1'b0);
        nop();
        // overflow: sticky error, resume ignored
        for (int i = 0; i < 5; i++) br(3'd5, 8'(8'h20 + 8'(i * 16)), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        do_rst(); nop();
        // underflow
        br(3'd6, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        do_rst(); nop();
        // HALT op and resume
        br(3'd0, 8'd7, 1'b0, 1'b0);
        br(3'd7, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        idle(1'b1);
        nop(); nop();
        // reset during a stall with a non-empty stack
        br(3'd5, 8'h60, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        do_rst();
        nop(); nop();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned k;
            k = $urandom_range(0, 99);
            if (k < 2 || ((m_ovf || m_unf) && k < 15)) begin
                do_rst();
            end else begin
                step(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                     3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3) == 0);
            end
        end
        rst = 1'b0;
        bus.instr_valid = 1'b1; bus.br_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
